// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
// Address-width rule, the hardwired zero entry index and the reset word pattern.
package regfile_pkg;

    localparam int  ZERO_IDX  = 0;
    localparam logic RESET_BIT = 1'b0;

    // Address width is clog2 of the entry count, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_wr_decode.sv
// One-hot write decoder: per-entry write enables from wr_en and wr_addr.
// Out-of-range addresses select nothing; entry 0 is masked when it is the zero register.
module regfile_wr_decode
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [DEPTH-1:0] wr_sel
);

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            wr_sel[ZERO_IDX] = 1'b0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);

    localparam logic [WIDTH-1:0] RESET_WORD = {WIDTH{RESET_BIT}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    regfile_wr_decode #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_wr_decode (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_sel  (wr_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_WORD;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // An address is live if it maps to a real entry that is not the hardwired zero.
    function automatic logic addr_live(input logic [AW-1:0] addr);
        return (32'(addr) < 32'(DEPTH)) && !((ZERO_REG != 0) && (addr == AW'(ZERO_IDX)));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] word;
        word = addr_live(addr) ? mem[addr] : RESET_WORD;
`ifdef REGFILE_BYPASS_EN
        // Forward only writes that will actually land; reset kills the forward.
        if (wr_en && !reset && (wr_addr == addr) && addr_live(addr)) begin
            word = wr_data;
        end
`endif
        return word;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three instances share stimulus
// (default config, ZERO_REG=0, and DEPTH=24 for out-of-range behaviour).
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra, rb;
    logic [31:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda0), .rd_addr_b(rb), .rd_data_b(rdb0));

    register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_nz (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda1), .rd_addr_b(rb), .rd_data_b(rdb1));

    register_file #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1)) u_d24 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda2), .rd_addr_b(rb), .rd_data_b(rdb2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set all inputs for the coming cycle, then let the read muxes settle.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        ra      = a;
        rb      = b;
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();

        // Reset state
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        chk("rst_a5",     rda0, 32'h0);
        chk("rst_b0",     rdb0, 32'h0);
        chk("rst_nz_a5",  rda1, 32'h0);
        chk("rst_d24_a5", rda2, 32'h0);

        // Pre-load every address with all ones
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'hFFFF_FFFF, 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd17);
        chk("pre_zero_a0",  rda0, 32'h0);
        chk("pre_b17",      rdb0, 32'hFFFF_FFFF);
        chk("pre_nz_a0",    rda1, 32'hFFFF_FFFF);
        chk("pre_d24_b17",  rdb2, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd23, 5'd24);
        chk("pre_d24_a23",  rda2, 32'hFFFF_FFFF);
        chk("pre_d24_b24",  rdb2, 32'h0);

        // Reset cycle still shows old contents, then clears everything
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        chk("rstcyc_a5",  rda0, 32'hFFFF_FFFF);
        chk("rstcyc_b31", rdb0, 32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            chk("clr_a",     rda0, 32'h0);
            chk("clr_b",     rdb0, 32'h0);
            chk("clr_nz_a",  rda1, 32'h0);
            chk("clr_d24_b", rdb2, 32'h0);
        end

        // Write/read at address 5
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
        chk("wr5_same_a", rda0, BYP ? 32'hDEAD_BEEF : 32'h0);
        chk("wr5_same_b6", rdb0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("rd5_a", rda0, 32'hDEAD_BEEF);
        chk("rd5_b", rdb0, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
        chk("rd6_a", rda0, 32'h0);

        // Zero register versus ordinary entry 0
        drive(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        chk("z_same_zr", rda0, 32'h0);
        chk("z_same_nz", rda1, BYP ? 32'h1234_5678 : 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("z_zr_a", rda0, 32'h0);
        chk("z_zr_b", rdb0, 32'h0);
        chk("z_nz_a", rda1, 32'h1234_5678);
        chk("z_nz_b", rdb1, 32'h1234_5678);

        // Same-cycle read of the write address
        drive(1'b0, 1'b1, 5'd3, 32'h0000_0011, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
        chk("fwd_same_a", rda0, BYP ? 32'hA5A5_A5A5 : 32'h0000_0011);
        chk("fwd_same_b", rdb0, BYP ? 32'hA5A5_A5A5 : 32'h0000_0011);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        chk("fwd_next_a", rda0, 32'hA5A5_A5A5);
        chk("fwd_next_b", rdb0, 32'hA5A5_A5A5);

        // Reset beats a simultaneous write, and suppresses forwarding
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0077, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd3);
        chk("rstwr_same_a", rda0, 32'h0000_0077);
        chk("rstwr_same_b", rdb0, 32'hA5A5_A5A5);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        chk("rstwr_a7", rda0, 32'h0);
        chk("rstwr_b3", rdb0, 32'h0);

        // Reset between back-to-back writes
        drive(1'b0, 1'b1, 5'd9, 32'h0909_0909, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd10, 32'h1010_1010, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
        chk("b2b_a9",  rda0, 32'h0);
        chk("b2b_b10", rdb0, 32'h1010_1010);

        // Out-of-range on the 24-deep instance
        drive(1'b0, 1'b1, 5'd30, 32'h5555_5555, 5'd30, 5'd30);
        chk("oor_same_d24", rda2, 32'h0);
        chk("oor_same_dut", rda0, BYP ? 32'h5555_5555 : 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd30);
        chk("oor_d24_a30", rda2, 32'h0);
        chk("oor_dut_a30", rda0, 32'h5555_5555);
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            chk("oor_d24_untouched", rda2, (i == 10) ? 32'h1010_1010 : 32'h0);
        end
        drive(1'b0, 1'b1, 5'd23, 32'h2323_2323, 5'd23, 5'd22);
        chk("d24_same_a23", rda2, BYP ? 32'h2323_2323 : 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd23, 5'd22);
        chk("d24_a23", rda2, 32'h2323_2323);
        chk("d24_b22", rdb2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
